// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the serial-bus arbiter.
package bus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEFAULT_NUM_INIT       = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    // Index width for n ports; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Initiator/target handshake lines seen by the arbiter.
// The master side drives requests and target responses.
// The slave side is the arbiter itself.
interface bus_arbiter_if #(
    parameter int NUM_INIT = 2,
    parameter int ID_W     = 1
);
    logic [NUM_INIT-1:0] arbiter_req;
    logic [NUM_INIT-1:0] arbiter_grant;
    logic                bus_busy;
    logic [ID_W-1:0]     owner_id;
    logic                target_ack;
    logic                target_split;
    logic                split_release;
    logic                split_pending;
    logic [ID_W-1:0]     split_id;
    logic                timeout;
    logic                split_overflow;

    modport master (
        output arbiter_req, target_ack, target_split, split_release,
        input  arbiter_grant, bus_busy, owner_id, split_pending, split_id,
               timeout, split_overflow
    );

    modport slave (
        input  arbiter_req, target_ack, target_split, split_release,
        output arbiter_grant, bus_busy, owner_id, split_pending, split_id,
               timeout, split_overflow
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requesting index at or after
// ptr wins, wrapping to the lowest requester when nothing sits above ptr.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);
    logic [N-1:0] upper;
    logic [N-1:0] pool;

    // Requests at or above the pointer take precedence over wrapped ones.
    for (genvar gi = 0; gi < N; gi++) begin : g_upper
        assign upper[gi] = req[gi] && (IW'(gi) >= ptr);
    end

    assign pool  = (|upper) ? upper : req;
    assign valid = |req;

    // Lowest set bit of the selected pool is the winner.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pool[i]) begin
                idx = IW'(i);
            end
        end
        grant = valid ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Serial-bus arbiter: round-robin grants, split parking with priority
// resume, and an optional per-grant watchdog.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT       = DEFAULT_NUM_INIT,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int ID_W           = id_width(NUM_INIT)
) (
    input logic        clk,
    input logic        rst,
    bus_arbiter_if.slave bus
);
    localparam int              WD_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_INIT - 1);

    arb_state_e          state_reg;
    logic [NUM_INIT-1:0] grant_reg;
    logic [ID_W-1:0]     owner_reg;
    logic [ID_W-1:0]     split_id_reg;
    logic [ID_W-1:0]     rr_ptr_reg;
    logic                busy_reg;
    logic                split_pending_reg;
    logic                split_resume_reg;
    logic                timeout_reg;
    logic                overflow_reg;
    logic [WD_W-1:0]     wd_cnt_reg;

    logic [NUM_INIT-1:0] park_mask;
    logic [NUM_INIT-1:0] eligible;
    logic [NUM_INIT-1:0] pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_valid;
    logic                resume_go;
    logic                wd_expire;
    logic [WD_W-1:0]     wd_next;

    function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] i);
        return (i == LAST_ID) ? '0 : i + ID_W'(1);
    endfunction

    // A parked initiator is hidden from normal arbitration until resumed.
    for (genvar gi = 0; gi < NUM_INIT; gi++) begin : g_mask
        assign park_mask[gi] = split_pending_reg && !split_resume_reg &&
                               (split_id_reg == ID_W'(gi));
    end

    assign eligible  = bus.arbiter_req & ~park_mask;
    assign resume_go = split_pending_reg && split_resume_reg && bus.arbiter_req[split_id_reg];
    assign wd_next   = wd_cnt_reg + WD_W'(1);
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_next == WD_W'(TIMEOUT_CYCLES));

    rr_pick #(
        .N  (NUM_INIT),
        .IW (ID_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Grant/release FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            grant_reg         <= '0;
            owner_reg         <= '0;
            busy_reg          <= 1'b0;
            split_pending_reg <= 1'b0;
            split_id_reg      <= '0;
            split_resume_reg  <= 1'b0;
            rr_ptr_reg        <= '0;
            wd_cnt_reg        <= '0;
            timeout_reg       <= 1'b0;
            overflow_reg      <= 1'b0;
        end else begin
            timeout_reg  <= 1'b0;
            overflow_reg <= 1'b0;

            // Resume requests latch until the parked initiator is granted.
            if (split_pending_reg && bus.split_release) begin
                split_resume_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    wd_cnt_reg <= '0;
                    if (resume_go) begin
                        grant_reg         <= NUM_INIT'(1) << split_id_reg;
                        owner_reg         <= split_id_reg;
                        busy_reg          <= 1'b1;
                        state_reg         <= BUSY;
                        rr_ptr_reg        <= inc_id(split_id_reg);
                        split_pending_reg <= 1'b0;
                        split_id_reg      <= '0;
                        split_resume_reg  <= 1'b0;
                    end else if (pick_valid) begin
                        grant_reg  <= pick_grant;
                        owner_reg  <= pick_idx;
                        busy_reg   <= 1'b1;
                        state_reg  <= BUSY;
                        rr_ptr_reg <= inc_id(pick_idx);
                    end
                end
                BUSY: begin
                    wd_cnt_reg <= wd_next;
                    if (bus.target_split || bus.target_ack ||
                        !bus.arbiter_req[owner_reg] || wd_expire) begin
                        grant_reg  <= '0;
                        owner_reg  <= '0;
                        busy_reg   <= 1'b0;
                        wd_cnt_reg <= '0;
                        state_reg  <= IDLE;
                        if (bus.target_split) begin
                            if (!split_pending_reg) begin
                                split_pending_reg <= 1'b1;
                                split_id_reg      <= owner_reg;
                            end else begin
                                overflow_reg <= 1'b1;
                            end
                        end else if (!bus.target_ack && bus.arbiter_req[owner_reg]) begin
                            timeout_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.arbiter_grant  = grant_reg;
    assign bus.bus_busy       = busy_reg;
    assign bus.owner_id       = owner_reg;
    assign bus.split_pending  = split_pending_reg;
    assign bus.split_id       = split_id_reg;
    assign bus.timeout        = timeout_reg;
    assign bus.split_overflow = overflow_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int N  = 2;
    localparam int TO = 8;
    localparam int IW = id_width(N);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model: who holds the bus (-1 none), how long, who is parked (-1 none).
    int m_owner, m_held, m_parked, m_rr;
    bit m_resume, m_timeout, m_overflow;

    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_INIT(N), .ID_W(IW)) bus ();

    bus_arbiter #(
        .NUM_INIT       (N),
        .TIMEOUT_CYCLES (TO),
        .ID_W           (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_in(input logic [N-1:0] req, input bit ack, input bit split, input bit srel);
        bus.arbiter_req   = req;
        bus.target_ack    = ack;
        bus.target_split  = split;
        bus.split_release = srel;
    endtask

    // Apply the arbitration rules to the inputs present before this edge.
    task automatic model_edge();
        logic [N-1:0] req;
        int  win;
        bit  pend_before;
        bit  resumed;
        req        = bus.arbiter_req;
        m_timeout  = 0;
        m_overflow = 0;
        if (rst) begin
            m_owner = -1; m_held = 0; m_parked = -1; m_resume = 0; m_rr = 0;
            return;
        end
        pend_before = (m_parked >= 0);
        resumed     = 0;
        if (m_owner < 0) begin
            win = -1;
            if (m_resume && m_parked >= 0 && req[m_parked]) begin
                win = m_parked; m_parked = -1; m_resume = 0; resumed = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_rr + k) % N;
                    if (win < 0 && req[i] && !(i == m_parked && !m_resume)) win = i;
                end
            end
            if (win >= 0) begin
                m_owner = win; m_held = 0; m_rr = (win + 1) % N;
            end
        end else begin
            m_held++;
            if (bus.target_split) begin
                if (m_parked < 0) m_parked = m_owner;
                else m_overflow = 1;
                m_owner = -1;
            end else if (bus.target_ack || !req[m_owner]) begin
                m_owner = -1;
            end else if (TO > 0 && m_held >= TO) begin
                m_timeout = 1; m_owner = -1;
            end
        end
        if (bus.split_release && pend_before && !resumed) m_resume = 1;
    endtask

    task automatic check_outputs();
        chk("grant",    32'(bus.arbiter_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("busy",     32'(bus.bus_busy),      32'(m_owner >= 0));
        chk("owner_id", 32'(bus.owner_id),      (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        chk("split_pending", 32'(bus.split_pending), 32'(m_parked >= 0));
        chk("split_id", 32'(bus.split_id),      (m_parked >= 0) ? 32'(m_parked) : 32'd0);
        chk("timeout",  32'(bus.timeout),       32'(m_timeout));
        chk("overflow", 32'(bus.split_overflow), 32'(m_overflow));
        chk("onehot",   32'($onehot0(bus.arbiter_grant)), 32'd1);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        $display("cyc %0d rst=%b req=%b ack=%b spl=%b rel=%b | grant=%b owner=%0d sp=%b sid=%0d to=%b ov=%b",
                 cyc, rst, bus.arbiter_req, bus.target_ack, bus.target_split, bus.split_release,
                 bus.arbiter_grant, bus.owner_id, bus.split_pending, bus.split_id,
                 bus.timeout, bus.split_overflow);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in('0, 0, 0, 0);
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int to_pulses;
        int r;
        m_owner = -1; m_held = 0; m_parked = -1; m_rr = 0;
        m_resume = 0; m_timeout = 0; m_overflow = 0;
        rst = 1'b1;
        set_in('0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        chk("reset_grant", 32'(bus.arbiter_grant), 32'd0);

        // Single request, then ack.
        set_in(2'b01, 0, 0, 0);
        cycle();
        chk("single_grant", 32'(bus.arbiter_grant), 32'h1);
        set_in(2'b01, 1, 0, 0);
        cycle();
        chk("ack_release_busy", 32'(bus.bus_busy), 32'd0);
        set_in('0, 0, 0, 0);
        cycle();

        // Fairness: both request, ack every fifth cycle.
        for (int i = 0; i < 24; i++) begin
            set_in(2'b11, (i % 5) == 4, 0, 0);
            cycle();
        end
        set_in('0, 0, 0, 0);
        cycle();
        cycle();

        // Split port0, serve port1, resume port0 with priority.
        do_reset();
        set_in(2'b11, 0, 0, 0);
        cycle();
        chk("split_first_grant", 32'(bus.arbiter_grant), 32'h1);
        set_in(2'b11, 0, 1, 0);
        cycle();
        chk("split_parked", 32'(bus.split_pending), 32'd1);
        chk("split_parked_id", 32'(bus.split_id), 32'd0);
        set_in(2'b11, 0, 0, 0);
        cycle();
        chk("split_other_grant", 32'(bus.arbiter_grant), 32'h2);
        set_in(2'b11, 0, 0, 1);
        cycle();
        set_in(2'b11, 1, 0, 0);
        cycle();
        set_in(2'b11, 0, 0, 0);
        cycle();
        chk("split_resume_grant", 32'(bus.arbiter_grant), 32'h1);
        chk("split_cleared", 32'(bus.split_pending), 32'd0);
        set_in(2'b11, 1, 0, 0);
        cycle();

        // Watchdog on port1, then port0 gets the bus.
        do_reset();
        to_pulses = 0;
        set_in(2'b10, 0, 0, 0);
        cycle();
        set_in(2'b11, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (bus.timeout) to_pulses++;
        end
        chk("timeout_pulses", 32'(to_pulses), 32'd1);
        chk("after_timeout_grant", 32'(bus.arbiter_grant), 32'h1);

        // Ack and split together count as split; second split overflows.
        set_in(2'b11, 1, 1, 0);
        cycle();
        chk("ack_split_parked", 32'(bus.split_pending), 32'd1);
        set_in(2'b11, 0, 0, 0);
        cycle();
        set_in(2'b11, 0, 1, 0);
        cycle();
        chk("overflow_pulse", 32'(bus.split_overflow), 32'd1);
        chk("overflow_sid", 32'(bus.split_id), 32'd0);
        set_in(2'b11, 0, 0, 0);
        cycle();

        // Reset while busy with a parked split.
        rst = 1'b1;
        cycle();
        chk("midreset_pending", 32'(bus.split_pending), 32'd0);
        rst = 1'b0;
        cycle();
        chk("post_reset_grant", 32'(bus.arbiter_grant), 32'h1);

        // Random traffic against the model.
        set_in('0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25) bus.arbiter_req = N'($urandom_range(0, (1 << N) - 1));
            bus.target_ack    = ($urandom_range(0, 99) < 15);
            bus.target_split  = ($urandom_range(0, 99) < 8);
            bus.split_release = ($urandom_range(0, 99) < 10);
            rst               = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
